// File: rtl/ab_datapath.sv
// ab_datapath: address counters, operand register, pair-sum adder and the two
// register-file memories (A holds loaded words, B holds pairwise sums with carry).
// The control unit upstream only sequences the WEA/IncA/IncB/WEB strobes.
module ab_datapath #(
  parameter int DATA_W = 8,
  parameter int AW_A   = 3,
  parameter int AW_B   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WEA,
  input  logic              IncA,
  input  logic              IncB,
  input  logic              WEB,
  input  logic [DATA_W-1:0] DataIn,
  output logic [AW_A-1:0]   AddrA,
  output logic [AW_B-1:0]   AddrB,
  output logic [DATA_W-1:0] DOut1,
  output logic [DATA_W-1:0] DOut2,
  output logic              Ovf,
  output logic              Done
);

  localparam int DEPTH_A = 1 << AW_A;
  localparam int DEPTH_B = 1 << AW_B;

  logic [AW_A-1:0]   r_addrA;
  logic [AW_B-1:0]   r_addrB;
  logic [DATA_W-1:0] r_opReg;
  logic              r_done;
  logic [DATA_W-1:0] r_memA [DEPTH_A];
  logic [DATA_W:0]   r_memB [DEPTH_B];

  logic [DATA_W-1:0] w_rdA;
  logic [DATA_W:0]   w_rdB;
  logic [DATA_W:0]   w_sum;
  logic              w_lastB;

  // Combinational reads; the sum always pairs the held operand with the word under AddrA.
  assign w_rdA   = r_memA[r_addrA];
  assign w_rdB   = r_memB[r_addrB];
  assign w_sum   = {1'b0, r_opReg} + {1'b0, w_rdA};
  assign w_lastB = (r_addrB == {AW_B{1'b1}});

  assign AddrA = r_addrA;
  assign AddrB = r_addrB;
  assign DOut1 = w_rdA;
  assign DOut2 = w_rdB[DATA_W-1:0];
  assign Ovf   = w_rdB[DATA_W];
  assign Done  = r_done;

  // A address counter, wraps naturally at the top of memory A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_addrA <= '0;
    else if (IncA) r_addrA <= r_addrA + 1'b1;
  end

  // B address counter, wraps naturally at the top of memory B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_addrB <= '0;
    else if (IncB) r_addrB <= r_addrB + 1'b1;
  end

  // Operand register captures the word being stepped past, but only on pure reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_opReg <= '0;
    else if (IncA && !WEA) r_opReg <= w_rdA;
  end

  // Sticky completion flag, raised by the write into the last B location.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else if (WEB && w_lastB) r_done <= 1'b1;
  end

  // Memory A write at the pre-increment address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_A; i++) r_memA[i] <= '0;
    end else if (WEA) begin
      r_memA[r_addrA] <= DataIn;
    end
  end

  // Memory B write of the 9-bit pair sum at the pre-increment address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_B; i++) r_memB[i] <= '0;
    end else if (WEB) begin
      r_memB[r_addrB] <= w_sum;
    end
  end

endmodule

// File: tb/tb_ab_datapath.sv
// Scoreboard bench for ab_datapath: stimulus updates a behavioural model and queues
// the expected post-edge outputs; an independent monitor pops and compares them.
module tb_ab_datapath;

  logic       clk;
  logic       rst;
  logic       WEA;
  logic       IncA;
  logic       IncB;
  logic       WEB;
  logic [7:0] DataIn;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic [7:0] DOut1;
  logic [7:0] DOut2;
  logic       Ovf;
  logic       Done;

  ab_datapath #(.DATA_W(8), .AW_A(3), .AW_B(2)) dut (
    .clk(clk), .rst(rst), .WEA(WEA), .IncA(IncA), .IncB(IncB), .WEB(WEB),
    .DataIn(DataIn), .AddrA(AddrA), .AddrB(AddrB), .DOut1(DOut1),
    .DOut2(DOut2), .Ovf(Ovf), .Done(Done)
  );

  typedef struct {
    int addrA;
    int addrB;
    int dout1;
    int dout2;
    int ovf;
    int done;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];
  event  sampleEv;
  int    checkCount = 0;
  int    passCount  = 0;

  // Behavioural model: plain integer arrays and modular address arithmetic.
  int mA[8];
  int mB[4];
  int mAddrA, mAddrB, mOp, mDone;

  int loadData[8] = '{10, 20, 30, 40, 250, 10, 0, 255};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mA[i] = 0;
    for (int i = 0; i < 4; i++) mB[i] = 0;
    mAddrA = 0;
    mAddrB = 0;
    mOp    = 0;
    mDone  = 0;
  endtask

  task automatic modelStep(input bit wea, input bit inca, input bit incb, input bit web, input int data);
    int rd;
    int sum;
    rd  = mA[mAddrA];
    sum = mOp + rd;
    if (web) begin
      mB[mAddrB] = sum;
      if (mAddrB == 3) mDone = 1;
    end
    if (wea) mA[mAddrA] = data;
    if (inca && !wea) mOp = rd;
    if (inca) mAddrA = (mAddrA + 1) % 8;
    if (incb) mAddrB = (mAddrB + 1) % 4;
  endtask

  task automatic pushExpected(input string tag);
    exp_t e;
    e.addrA = mAddrA;
    e.addrB = mAddrB;
    e.dout1 = mA[mAddrA];
    e.dout2 = mB[mAddrB] % 256;
    e.ovf   = mB[mAddrB] / 256;
    e.done  = mDone;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic checkField(input string tag, input string name, input int act, input int req);
    checkCount++;
    if (act == req) passCount++;
    else $display("[TB] FAIL %s.%s actual=%0d required=%0d", tag, name, act, req);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField(tag, "AddrA", int'(AddrA), e.addrA);
    checkField(tag, "AddrB", int'(AddrB), e.addrB);
    checkField(tag, "DOut1", int'(DOut1), e.dout1);
    checkField(tag, "DOut2", int'(DOut2), e.dout2);
    checkField(tag, "Ovf",   int'(Ovf),   e.ovf);
    checkField(tag, "Done",  int'(Done),  e.done);
  endtask

  // Monitor: after each rising edge (or an asynchronous event) compare everything queued.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk or sampleEv);
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(e, t);
      end
    end
  end

  // One clock of strobes, driven mid-cycle and modelled for the coming edge.
  task automatic applyStimulus(input bit wea, input bit inca, input bit incb, input bit web,
                               input int data, input string tag);
    @(negedge clk);
    WEA    = wea;
    IncA   = inca;
    IncB   = incb;
    WEB    = web;
    DataIn = 8'(data);
    modelStep(wea, inca, incb, web, data);
    pushExpected(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    WEA  = 1'b0;
    IncA = 1'b0;
    IncB = 1'b0;
    WEB  = 1'b0;
    rst  = 1'b1;
    modelReset();
    pushExpected(tag);
    ->sampleEv;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadA(input string tag);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, loadData[i], tag);
  endtask

  task automatic sumPhase(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      if (mAddrA % 2 == 1) applyStimulus(0, 1, 1, 1, 0, tag);
      else applyStimulus(0, 1, 0, 0, 0, tag);
    end
  endtask

  // Directed scenarios followed by randomized strobes.
  initial begin
    rst    = 1'b1;
    WEA    = 1'b0;
    IncA   = 1'b0;
    IncB   = 1'b0;
    WEB    = 1'b0;
    DataIn = '0;
    modelReset();
    doReset("initReset");

    loadA("loadA");
    sumPhase(8, "pairSums");
    applyStimulus(0, 0, 0, 0, 0, "doneHold");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, "readB");

    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, 0, "wrapB");
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0, 0, "wrapA");

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, "toAddr5");
    applyStimulus(1, 1, 0, 0, 8'h5A, "weaIncA5");
    applyStimulus(0, 0, 0, 1, 0, "opHeld");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, "readBack5");

    applyStimulus(1, 1, 1, 1, 77, "allStrobes");
    applyStimulus(1, 0, 0, 1, 33, "weaWeb");

    doReset("preReload");
    loadA("reload");
    sumPhase(4, "partialSums");
    doReset("midReadReset");
    loadA("freshLoad");
    sumPhase(8, "freshSums");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, "freshReadB");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(63) == 0) doReset("rndReset");
      else applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                         1'($urandom_range(1)), int'($urandom_range(255)), "random");
    end
    applyStimulus(0, 0, 0, 0, 0, "idle");

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ab_datapath.md
# ab_datapath

Datapath stage directly downstream of the control unit. It consumes the unit's `WEA`, `IncA`, `IncB` and `WEB` strobes and owns two register-file memories:
- Memory A (8 x 8) is loaded from `DataIn`.
- Memory B (4 x 9) receives the 9-bit sum of each consecutive pair of A words: A[0]+A[1], A[2]+A[3], and so on.

Address counters, the operand register and the completion flag all live here. The control unit only sequences the strobes.

## Interface
- `DATA_W`, 8, width of A words; B words are `DATA_W+1` (sum plus carry)
- `AW_A`, 3, address width of memory A (depth 2^AW_A = 8)
- `AW_B`, 2, address width of memory B (depth 2^AW_B = 4); must equal `AW_A-1`

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `WEA`  in  1  write `DataIn` into A[AddrA]
- `IncA`  in  1  increment AddrA
- `IncB`  in  1  increment AddrB
- `WEB`  in  1  write pair sum into B[AddrB]
- `DataIn`  in  DATA_W  load data for memory A
- `AddrA`  out  AW_A  current A address
- `AddrB`  out  AW_B  current B address
- `DOut1`  out  DATA_W  A[AddrA], combinational read
- `DOut2`  out  DATA_W  B[AddrB][DATA_W-1:0], combinational read
- `Ovf`  out  1  B[AddrB][DATA_W], carry of the stored sum
- `Done`  out  1  sticky, set after the last B location is written

## Operation
- Reset (async, `rst`=1) clears AddrA, AddrB, `OpReg`, `Done`, and every A and B location to 0.
  - Consequence: all outputs read 0 during and after reset until the first update.
- AddrA: on `IncA`, AddrA <= AddrA+1 mod 8 (7 -> 0 wraps). AddrB: on `IncB`, AddrB <= AddrB+1 mod 4 (3 -> 0 wraps).
- Memory A write: on `WEA`, A[AddrA] <= DataIn. The address used is the pre-increment AddrA, even when `IncA` is asserted in the same cycle.
- Operand register: on `IncA` with `WEA`=0, OpReg <= DOut1, which captures the word being stepped past. When `WEA`=1, OpReg holds its value.
- Sum: Sum = {1'b0,OpReg} + {1'b0,DOut1}. This is a 9-bit combinational result with no saturation; the carry is kept in bit 8.
  - Valid pairing: when AddrA is odd during the read phase, OpReg = A[AddrA-1] and DOut1 = A[AddrA].
- Memory B write: on `WEB`, B[AddrB] <= Sum, at the pre-increment AddrB when `IncB` is in the same cycle.
- `WEB` is honoured regardless of AddrA parity. The block does not police pairing; correct pairing is the control unit's responsibility.
- Done: set on the edge where `WEB`=1 and AddrB=3. It stays set until `rst`; further writes do not clear it.
- Simultaneous strobes:
  - `WEA`+`WEB` in one cycle: both writes occur. Sum uses the pre-write A contents.
  - All four strobes asserted: all four actions occur, using pre-edge values.
- Reset mid-operation: all state returns to 0 asynchronously, with no partial write. Strobes seen on the first edge after `rst` deasserts are acted on normally.

## Timing
- All registered state changes on the rising edge of `clk`. `rst` acts immediately (asynchronously) on assertion.
- `DOut1`, `DOut2` and `Ovf` are combinational from the addresses and memory contents:
  - A write becomes visible on `DOut1` in the cycle after the write edge, if AddrA still points there.
- AddrA/AddrB change one cycle after `IncA`/`IncB` is sampled high. `Done` rises one cycle after the final `WEB`.
- Latency from OpReg capture to B write: minimum 1 cycle. The sequence is `IncA` (read A[2k]), then `WEB` with AddrA = 2k+1.
- There is no backpressure and no handshake; every strobe takes effect on the edge where it is sampled.

## Test plan
- Reset check: assert `rst` mid-cycle with nonzero state. Required: AddrA=0, AddrB=0, DOut1=0, DOut2=0, Ovf=0, Done=0 immediately, without waiting for a clock edge.
- Load A: 8 cycles of `WEA`+`IncA` with DataIn = 10,20,30,40,250,10,0,255. Required: AddrA wraps to 0, and then stepping `IncA` shows DOut1 = 10,20,30,40,250,10,0,255.
- Pair sums: read phase with `IncA` every cycle, `WEB`+`IncB` when AddrA is odd. Required:
  - B = {30, 70, 0x04 with Ovf=1, 255 with Ovf=0}
  - Done=1 one cycle after the fourth `WEB`.
- Wrap: 9 `IncB` pulses from 0. Required: AddrB = 1. 9 `IncA` pulses from 0. Required: AddrA = 1.
- Same-cycle `WEA`+`IncA` at AddrA=5 with DataIn=0x5A. Required: A[5]=0x5A, AddrA=6, and OpReg unchanged.
- Reset during read phase after two B writes. Required: B contents and Done return to 0. A fresh load/sum sequence then reproduces the pair-sums results exactly.
